udt_encode: RTL and testbench

//  Transmit-side framer for the UDT packet path; the inverse of the decode stage.

---
 rtl/udt_encode.sv | 123 ++++++++++++
 tb/tb_udt_encode.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udt_encode.sv
// UDT transmit framer: emits a {type,info} header beat followed by the optional
// payload, with a single-stage output register and truncation at MAX_BEATS.
module udt_encode #(
  parameter int unsigned MAX_BEATS = 188,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             core_rst_n,
  input  logic             hdr_valid,
  output logic             hdr_ready,
  input  logic [15:0]      hdr_type,
  input  logic [47:0]      hdr_info,
  input  logic             hdr_nopay,
  input  logic             in_tvalid,
  output logic             in_tready,
  input  logic [63:0]      in_tdata,
  input  logic [7:0]       in_tkeep,
  input  logic             in_tlast,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic [63:0]      out_tdata,
  output logic [7:0]       out_tkeep,
  output logic             out_tlast,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic             trunc_err
);

  localparam int unsigned BW = $clog2(MAX_BEATS + 1);
  localparam logic [BW-1:0] LAST_IDX = BW'(MAX_BEATS - 1);

  typedef enum logic [1:0] {IDLE, BODY, DROP} state_e;

  state_e           state_q;
  logic [BW-1:0]    beat_cnt_q;
  logic             out_tvalid_q;
  logic [63:0]      out_tdata_q;
  logic [7:0]       out_tkeep_q;
  logic             out_tlast_q;
  logic [CNT_W-1:0] pkt_cnt_q;
  logic             trunc_err_q;

  logic adv;
  logic hdr_fire;
  logic in_fire;
  logic out_fire;

  assign adv      = !out_tvalid_q || out_tready;
  assign hdr_fire = hdr_valid && hdr_ready;
  assign in_fire  = in_tvalid && in_tready;
  assign out_fire = out_tvalid_q && out_tready;

  always_comb begin
    hdr_ready = 1'b0;
    in_tready = 1'b0;
    case (state_q)
      IDLE:    hdr_ready = adv;
      BODY:    in_tready = adv;
      DROP:    in_tready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      out_tvalid_q <= 1'b0;
      out_tdata_q  <= '0;
      out_tkeep_q  <= '0;
      out_tlast_q  <= 1'b0;
      pkt_cnt_q    <= '0;
      trunc_err_q  <= 1'b0;
    end else begin
      trunc_err_q <= 1'b0;
      if (out_fire && out_tlast_q) pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
      case (state_q)
        IDLE: begin
          if (hdr_fire) begin
            out_tvalid_q <= 1'b1;
            out_tdata_q  <= {hdr_type, hdr_info};
            out_tkeep_q  <= '1;
            out_tlast_q  <= hdr_nopay;
            beat_cnt_q   <= '0;
            state_q      <= hdr_nopay ? IDLE : BODY;
          end else if (adv) begin
            out_tvalid_q <= 1'b0;
          end
        end
        BODY: begin
          if (in_fire) begin
            out_tvalid_q <= 1'b1;
            out_tdata_q  <= in_tdata;
            out_tkeep_q  <= in_tkeep;
            out_tlast_q  <= in_tlast || (beat_cnt_q == LAST_IDX);
            beat_cnt_q   <= beat_cnt_q + BW'(1);
            // A natural tlast on the final allowed beat is not a truncation.
            if (in_tlast) begin
              state_q <= IDLE;
            end else if (beat_cnt_q == LAST_IDX) begin
              trunc_err_q <= 1'b1;
              state_q     <= DROP;
            end
          end else if (adv) begin
            out_tvalid_q <= 1'b0;
          end
        end
        DROP: begin
          if (adv) out_tvalid_q <= 1'b0;
          if (in_fire && in_tlast) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_tvalid = out_tvalid_q;
  assign out_tdata  = out_tdata_q;
  assign out_tkeep  = out_tkeep_q;
  assign out_tlast  = out_tlast_q;
  assign pkt_cnt    = pkt_cnt_q;
  assign trunc_err  = trunc_err_q;

endmodule

// File: tb/tb_udt_encode.sv
// Bench for udt_encode: drives packets and checks the framed stream against a
// packet-level scoreboard, with a second instance (MAX_BEATS=4, CNT_W=3) for truncation and wrap.
module tb_udt_encode;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        hdr_valid;
  logic [15:0] hdr_type;
  logic [47:0] hdr_info;
  logic        hdr_nopay;
  logic        in_tvalid;
  logic [63:0] in_tdata;
  logic [7:0]  in_tkeep;
  logic        in_tlast;
  logic        out_tready;
  logic        sel;

  logic        a_hdr_ready, a_in_tready, a_out_tvalid, a_out_tlast, a_trunc;
  logic [63:0] a_out_tdata;
  logic [7:0]  a_out_tkeep;
  logic [31:0] a_pkt_cnt;
  logic        t_hdr_ready, t_in_tready, t_out_tvalid, t_out_tlast, t_trunc;
  logic [63:0] t_out_tdata;
  logic [7:0]  t_out_tkeep;
  logic [2:0]  t_pkt_cnt;

  udt_encode #(.MAX_BEATS(188), .CNT_W(32)) u_dut (
    .clk(clk), .core_rst_n(rst_n),
    .hdr_valid(hdr_valid & ~sel), .hdr_ready(a_hdr_ready),
    .hdr_type(hdr_type), .hdr_info(hdr_info), .hdr_nopay(hdr_nopay),
    .in_tvalid(in_tvalid & ~sel), .in_tready(a_in_tready),
    .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tlast(in_tlast),
    .out_tvalid(a_out_tvalid), .out_tready(out_tready),
    .out_tdata(a_out_tdata), .out_tkeep(a_out_tkeep), .out_tlast(a_out_tlast),
    .pkt_cnt(a_pkt_cnt), .trunc_err(a_trunc)
  );

  udt_encode #(.MAX_BEATS(4), .CNT_W(3)) u_dut_trunc (
    .clk(clk), .core_rst_n(rst_n),
    .hdr_valid(hdr_valid & sel), .hdr_ready(t_hdr_ready),
    .hdr_type(hdr_type), .hdr_info(hdr_info), .hdr_nopay(hdr_nopay),
    .in_tvalid(in_tvalid & sel), .in_tready(t_in_tready),
    .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tlast(in_tlast),
    .out_tvalid(t_out_tvalid), .out_tready(out_tready),
    .out_tdata(t_out_tdata), .out_tkeep(t_out_tkeep), .out_tlast(t_out_tlast),
    .pkt_cnt(t_pkt_cnt), .trunc_err(t_trunc)
  );

  logic        hdr_rdy, in_rdy, o_valid, o_last, o_trunc;
  logic [63:0] o_data;
  logic [7:0]  o_keep;
  logic [31:0] o_cnt;
  assign hdr_rdy = sel ? t_hdr_ready  : a_hdr_ready;
  assign in_rdy  = sel ? t_in_tready  : a_in_tready;
  assign o_valid = sel ? t_out_tvalid : a_out_tvalid;
  assign o_last  = sel ? t_out_tlast  : a_out_tlast;
  assign o_trunc = sel ? t_trunc      : a_trunc;
  assign o_data  = sel ? t_out_tdata  : a_out_tdata;
  assign o_keep  = sel ? t_out_tkeep  : a_out_tkeep;
  assign o_cnt   = sel ? {29'd0, t_pkt_cnt} : a_pkt_cnt;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          passes = 0;
  int unsigned model_cnt = 0;
  int unsigned trunc_exp = 0;
  int unsigned trunc_seen = 0;
  bit          mon_en = 1'b0;
  bit          no_in = 1'b0;
  int unsigned rdy_mode = 0;

  function automatic int unsigned cur_max();
    return sel ? 4 : 188;
  endfunction

  function automatic logic [31:0] exp_cnt();
    return sel ? (model_cnt % 8) : model_cnt;
  endfunction

  // Downstream ready: 0 = always ready, 1 = 1,0,0 pattern, 2 = random.
  initial begin
    int unsigned ph = 0;
    out_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: begin out_tready = (ph == 0); ph = (ph + 1) % 3; end
        2: out_tready = ($urandom_range(0, 3) != 0);
        default: out_tready = 1'b1;
      endcase
    end
  end

  // Output monitor: scoreboard, stall hold, pulse width, ready coupling.
  initial begin
    bit pv = 0, pr = 0, pl = 0, ptr = 0;
    logic [63:0] pd = '0;
    logic [7:0]  pk = '0;
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        pv = 0; ptr = 0;
      end else begin
        if (pv && !pr) begin
          checks++;
          if ({o_valid, o_data, o_keep, o_last} !== {1'b1, pd, pk, pl})
            $display("FAIL stall_hold: got v=%b d=%h k=%h l=%b, want v=1 d=%h k=%h l=%b",
                     o_valid, o_data, o_keep, o_last, pd, pk, pl);
          else passes++;
        end
        if (o_valid && !out_tready && !sel) begin
          checks++;
          if (in_rdy !== 1'b0) $display("FAIL in_tready_stall: got %b want 0", in_rdy);
          else passes++;
        end
        if (no_in) begin
          checks++;
          if (in_rdy !== 1'b0) $display("FAIL in_tready_hdr_only: got %b want 0", in_rdy);
          else passes++;
        end
        if (o_trunc) begin
          trunc_seen++;
          checks++;
          if (ptr) $display("FAIL trunc_pulse_width: got 2+ cycles want 1");
          else passes++;
        end
        if (o_valid && out_tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL extra_beat: got d=%h l=%b want none", o_data, o_last);
          end else begin
            e = exp_q.pop_front();
            if ({o_data, o_keep, o_last} !== e)
              $display("FAIL beat: got d=%h k=%h l=%b want d=%h k=%h l=%b",
                       o_data, o_keep, o_last, e.d, e.k, e.l);
            else passes++;
          end
          if (o_last) begin
            checks++;
            if (o_cnt !== exp_cnt()) $display("FAIL pkt_cnt_at_tlast: got %0d want %0d", o_cnt, exp_cnt());
            else passes++;
            model_cnt++;
          end
        end
        pv = o_valid; pr = out_tready; pd = o_data; pk = o_keep; pl = o_last; ptr = o_trunc;
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // Expected framed output built from the packet, independent of handshake timing.
  task automatic model_pkt(input logic [15:0] ty, input logic [47:0] inf, input bit nop,
                           input beat_t pay[$]);
    beat_t b;
    int unsigned n;
    b.d = {ty, inf}; b.k = 8'hFF; b.l = nop;
    exp_q.push_back(b);
    if (!nop) begin
      n = (pay.size() < cur_max()) ? pay.size() : cur_max();
      for (int unsigned i = 0; i < n; i++) begin
        b = pay[i];
        b.l = (i == n - 1);
        exp_q.push_back(b);
      end
      if (pay.size() > cur_max()) trunc_exp++;
    end
  endtask

  task automatic hs_hdr(input logic [15:0] ty, input logic [47:0] inf, input bit nop, output bit ok);
    hdr_valid = 1'b1; hdr_type = ty; hdr_info = inf; hdr_nopay = nop;
    ok = 1'b0;
    for (int unsigned n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk); ok = hdr_rdy;
      @(posedge clk); #1;
    end
    hdr_valid = 1'b0;
    checks++;
    if (!ok) $display("FAIL hdr_accept: got no hdr_ready want accept within 2000 cycles");
    else passes++;
  endtask

  task automatic hs_beat(input beat_t b, output bit ok);
    in_tvalid = 1'b1; in_tdata = b.d; in_tkeep = b.k; in_tlast = b.l;
    ok = 1'b0;
    for (int unsigned n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk); ok = in_rdy;
      @(posedge clk); #1;
    end
    in_tvalid = 1'b0;
    checks++;
    if (!ok) $display("FAIL beat_accept: got no in_tready want accept within 2000 cycles");
    else passes++;
  endtask

  task automatic send_pkt(input logic [15:0] ty, input logic [47:0] inf, input bit nop,
                          input int unsigned len, input logic [63:0] base, input bit rnd, input bit gaps);
    beat_t pay[$];
    beat_t b;
    bit ok;
    for (int unsigned i = 0; i < len; i++) begin
      b.d = rnd ? {$urandom, $urandom} : base + 64'(i + 1);
      b.k = rnd ? 8'($urandom) : 8'hFF;
      b.l = (i == len - 1);
      pay.push_back(b);
    end
    model_pkt(ty, inf, nop, pay);
    hs_hdr(ty, inf, nop, ok);
    if (!ok) return;
    for (int unsigned i = 0; i < pay.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      hs_beat(pay[i], ok);
      if (!ok) return;
    end
  endtask

  task automatic do_reset();
    hdr_valid = 0; in_tvalid = 0; hdr_nopay = 0; in_tlast = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_q.delete(); model_cnt = 0; trunc_exp = 0; trunc_seen = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int unsigned n = 0; n < 5000 && exp_q.size() != 0; n++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) $display("FAIL drain: got %0d beats outstanding want 0", exp_q.size());
    else passes++;
    checks++;
    if (o_cnt !== exp_cnt()) $display("FAIL pkt_cnt_final: got %0d want %0d", o_cnt, exp_cnt());
    else passes++;
    checks++;
    if (trunc_seen != trunc_exp) $display("FAIL trunc_count: got %0d want %0d", trunc_seen, trunc_exp);
    else passes++;
  endtask

  task automatic test_reset();
    beat_t b;
    bit ok;
    sel = 0; rdy_mode = 0; mon_en = 0;
    hdr_valid = 0; in_tvalid = 0; hdr_nopay = 0; in_tlast = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_valid, o_last, o_data, o_keep, o_cnt, o_trunc} !== '0)
      $display("FAIL reset_values: got v=%b l=%b d=%h k=%h cnt=%0d te=%b want all 0",
               o_valid, o_last, o_data, o_keep, o_cnt, o_trunc);
    else passes++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    hs_hdr(16'h0000, 48'h0000_1234_5678, 1'b0, ok);
    for (int unsigned i = 0; i < 3; i++) begin
      b.d = 64'hAAAA_0000_0000_0000 + 64'(i); b.k = 8'hFF; b.l = 1'b0;
      hs_beat(b, ok);
    end
    @(negedge clk);
    checks++;
    if (in_rdy !== 1'b1) $display("FAIL mid_body: got in_tready=%b want 1", in_rdy);
    else passes++;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_valid, o_cnt} !== '0) $display("FAIL reset_mid_pkt: got v=%b cnt=%0d want 0 0", o_valid, o_cnt);
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({hdr_rdy, in_rdy, o_valid, o_last} !== 4'b1000)
      $display("FAIL post_reset: got hdr_ready=%b in_tready=%b v=%b l=%b want 1 0 0 0",
               hdr_rdy, in_rdy, o_valid, o_last);
    else passes++;
    @(posedge clk); #1;
    mon_en = 1;
  endtask

  task automatic test_data_pkt();
    sel = 0; rdy_mode = 0; do_reset();
    send_pkt(16'h0000, 48'h0, 1'b0, 10, 64'h8111_0000_0000_0000, 1'b0, 1'b0);
    drain();
    checks++;
    if (o_cnt !== 32'd1) $display("FAIL data_pkt_cnt: got %0d want 1", o_cnt);
    else passes++;
  endtask

  task automatic test_ctrl_back_to_back();
    logic [15:0] types [6] = '{16'h8000, 16'h8001, 16'h8002, 16'h8003, 16'h8005, 16'h8006};
    sel = 0; rdy_mode = 0; do_reset();
    foreach (types[i])
      send_pkt(types[i], 48'h0, 1'b0, 10, {types[i], 48'h0}, 1'b0, 1'b0);
    drain();
    checks++;
    if (o_cnt !== 32'd6) $display("FAIL ctrl_pkt_cnt: got %0d want 6", o_cnt);
    else passes++;
  endtask

  task automatic test_backpressure();
    sel = 0; rdy_mode = 1; do_reset();
    send_pkt(16'h0000, 48'h0, 1'b0, 10, 64'h8111_0000_0000_0000, 1'b0, 1'b0);
    drain();
    checks++;
    if (o_cnt !== 32'd1) $display("FAIL bp_pkt_cnt: got %0d want 1", o_cnt);
    else passes++;
  endtask

  task automatic test_hdr_only();
    sel = 0; rdy_mode = 0; do_reset();
    no_in = 1;
    send_pkt(16'h8002, 48'hBEEF_0000_CAFE, 1'b1, 0, 64'h0, 1'b0, 1'b0);
    send_pkt(16'h8002, 48'h0000_0000_0001, 1'b1, 0, 64'h0, 1'b0, 1'b0);
    drain();
    no_in = 0;
    checks++;
    if (o_cnt !== 32'd2) $display("FAIL hdr_only_cnt: got %0d want 2", o_cnt);
    else passes++;
  endtask

  task automatic test_random();
    logic [63:0] r;
    logic [15:0] ty;
    bit nop;
    sel = 0; rdy_mode = 2; do_reset();
    for (int i = 0; i < 14; i++) begin
      r = {$urandom, $urandom};
      ty = ($urandom_range(0, 1) == 1) ? 16'(16'h8000 + $urandom_range(0, 6)) : 16'($urandom_range(0, 16'h7FFF));
      nop = ($urandom_range(0, 3) == 0);
      send_pkt(ty, r[47:0], nop, nop ? 0 : $urandom_range(1, 20), 64'h0, 1'b1, 1'b1);
    end
    drain();
  endtask

  task automatic test_boundary_188();
    sel = 0; rdy_mode = 2; do_reset();
    send_pkt(16'h0001, 48'h1, 1'b0, 188, 64'h0, 1'b1, 1'b0);
    send_pkt(16'h0002, 48'h2, 1'b0, 189, 64'h0, 1'b1, 1'b0);
    send_pkt(16'h8006, 48'h3, 1'b0, 190, 64'h0, 1'b1, 1'b0);
    send_pkt(16'h0004, 48'h4, 1'b0, 1, 64'h0, 1'b1, 1'b0);
    drain();
    checks++;
    if (trunc_seen != 2) $display("FAIL trunc_188: got %0d pulses want 2", trunc_seen);
    else passes++;
  endtask

  task automatic test_truncation();
    logic [63:0] r;
    sel = 1; rdy_mode = 0; do_reset();
    send_pkt(16'h0000, 48'h0, 1'b0, 6, 64'h8111_0000_0000_0000, 1'b0, 1'b0);
    send_pkt(16'h0005, 48'h55, 1'b0, 2, 64'h5000_0000_0000_0000, 1'b0, 1'b0);
    send_pkt(16'h8001, 48'h66, 1'b0, 4, 64'h6000_0000_0000_0000, 1'b0, 1'b0);
    send_pkt(16'h8006, 48'h77, 1'b0, 5, 64'h7000_0000_0000_0000, 1'b0, 1'b0);
    rdy_mode = 2;
    for (int i = 0; i < 7; i++) begin
      r = {$urandom, $urandom};
      send_pkt(16'($urandom), r[47:0], 1'b0, $urandom_range(1, 7), 64'h0, 1'b1, 1'b1);
    end
    drain();
    checks++;
    if (o_cnt !== 32'd3) $display("FAIL pkt_cnt_wrap: got %0d want 3", o_cnt);
    else passes++;
  endtask

  initial begin
    sel = 0; rst_n = 0;
    hdr_valid = 0; hdr_type = '0; hdr_info = '0; hdr_nopay = 0;
    in_tvalid = 0; in_tdata = '0; in_tkeep = '0; in_tlast = 0;
    test_reset();
    test_data_pkt();
    test_ctrl_back_to_back();
    test_backpressure();
    test_hdr_only();
    test_random();
    test_boundary_188();
    test_truncation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
